// File: rtl/cfg_pkg.sv
// Shared types and constants for the configuration scan-chain loader.
// The chain-length helper sizes a single CLB chain: config FF, input selects and LUT.
package cfg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } cfg_state_e;

  localparam int WORD_WIDTH_DEF = 8;

  // ble_num below 1 describes an empty fabric and therefore an empty chain
  function automatic int clb_chain_len(input int in_width, input int sel_width, input int ble_num);
    if (ble_num < 1) return 0;
    return 1 + in_width * sel_width + 2 ** in_width;
  endfunction

  localparam int CHAIN_LEN_DEF = clb_chain_len(4, 3, 1);

endpackage

// File: rtl/cfg_word_piso.sv
// Parallel-in serial-out word buffer, LSB first, tracking how many bits remain valid.
// Exposes next-cycle empty/last flags so the owner can register its handshake outputs.
module cfg_word_piso
  import cfg_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH_DEF,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             flush_i,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] word_i,
  input  logic [CNT_W-1:0] nbits_i,
  output logic             lsb_o,
  output logic             empty_nxt_o,
  output logic             last_nxt_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A load on the same edge as the final shift replaces the spent word, so there is no bubble
  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      data_d = '0;
      cnt_d  = '0;
    end else if (load_i) begin
      data_d = word_i;
      cnt_d  = nbits_i;
    end else if (shift_i && (cnt_q != '0)) begin
      data_d = data_q >> 1;
      cnt_d  = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign lsb_o       = data_q[0];
  assign empty_nxt_o = (cnt_d == '0);
  assign last_nxt_o  = (cnt_d == CNT_W'(1));

endmodule

// File: rtl/cfg_scan_loader.sv
// Streams host configuration words LSB-first into the CLB scan chain, counts exactly
// CHAIN_LEN issued bits, returns the old chain contents and holds the fabric in reset meanwhile.
module cfg_scan_loader
  import cfg_pkg::*;
#(
  parameter int CHAIN_LEN  = CHAIN_LEN_DEF,
  parameter int WORD_WIDTH = WORD_WIDTH_DEF,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [WORD_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  scan_in,
  output logic                  scan_en,
  output logic                  scan_clk_en,
  input  logic                  scan_out,
  output logic                  rb_bit,
  output logic                  rb_valid,
  output logic                  busy,
  output logic                  cfg_done,
  output logic                  fabric_reset
);

  localparam int PW = $clog2(WORD_WIDTH + 1);
  localparam logic [CNT_WIDTH-1:0] LEN_C  = CNT_WIDTH'(CHAIN_LEN);
  localparam logic [CNT_WIDTH-1:0] LAST_C = CNT_WIDTH'(CHAIN_LEN - 1);
  localparam logic [CNT_WIDTH-1:0] WW_C   = CNT_WIDTH'(WORD_WIDTH);

  cfg_state_e           state_q, state_d;
  logic [CNT_WIDTH-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_WIDTH-1:0] remain;
  logic [PW-1:0]        nbits;

  logic word_ready_q, word_ready_d;
  logic scan_en_q, scan_en_d;
  logic scan_clk_en_q, scan_clk_en_d;
  logic rb_bit_q, rb_bit_d;
  logic rb_valid_q, rb_valid_d;
  logic busy_q, busy_d;
  logic cfg_done_q, cfg_done_d;
  logic fabric_reset_q, fabric_reset_d;

  logic accept, issue, piso_flush, piso_lsb, piso_empty_nxt, piso_last_nxt;

  assign accept     = word_valid && word_ready_q;
  assign issue      = scan_clk_en_q;
  assign piso_flush = abort || (state_q != LOAD);

  // acc_q counts bits committed to the buffer; the final word is trimmed to what the chain still needs
  assign remain = LEN_C - acc_q;
  assign nbits  = (remain >= WW_C) ? PW'(WORD_WIDTH) : remain[PW-1:0];

  cfg_word_piso #(
    .WIDTH (WORD_WIDTH),
    .CNT_W (PW)
  ) u_piso (
    .clk_i       (clk),
    .reset_i     (reset),
    .flush_i     (piso_flush),
    .load_i      (accept),
    .shift_i     (issue),
    .word_i      (word_data),
    .nbits_i     (nbits),
    .lsb_o       (piso_lsb),
    .empty_nxt_o (piso_empty_nxt),
    .last_nxt_o  (piso_last_nxt)
  );

  always_comb begin : next_state
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    acc_d     = acc_q;
    if (abort) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      acc_d     = '0;
    end else begin
      case (state_q)
        IDLE: begin
          bit_cnt_d = '0;
          acc_d     = '0;
          if (start) state_d = LOAD;
        end
        LOAD: begin
          if (accept) acc_d = acc_q + CNT_WIDTH'(nbits);
          if (issue) begin
            bit_cnt_d = bit_cnt_q + CNT_WIDTH'(1);
            if (bit_cnt_q == LAST_C) state_d = DONE;
          end
        end
        DONE: begin
          if (start) begin
            state_d   = LOAD;
            bit_cnt_d = '0;
            acc_d     = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are computed from next-state values so every port comes straight off a flop
  always_comb begin : outputs
    busy_d         = (state_d == LOAD);
    scan_en_d      = (state_d == LOAD);
    scan_clk_en_d  = (state_d == LOAD) && !piso_empty_nxt;
    word_ready_d   = (state_d == LOAD) && (acc_d < LEN_C) && (piso_empty_nxt || piso_last_nxt);
    cfg_done_d     = (state_d == DONE);
    fabric_reset_d = !((state_q == DONE) && (state_d == DONE));
    rb_valid_d     = scan_clk_en_q;
    rb_bit_d       = scan_clk_en_q ? scan_out : rb_bit_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      bit_cnt_q      <= '0;
      acc_q          <= '0;
      word_ready_q   <= 1'b0;
      scan_en_q      <= 1'b0;
      scan_clk_en_q  <= 1'b0;
      rb_bit_q       <= 1'b0;
      rb_valid_q     <= 1'b0;
      busy_q         <= 1'b0;
      cfg_done_q     <= 1'b0;
      fabric_reset_q <= 1'b1;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      acc_q          <= acc_d;
      word_ready_q   <= word_ready_d;
      scan_en_q      <= scan_en_d;
      scan_clk_en_q  <= scan_clk_en_d;
      rb_bit_q       <= rb_bit_d;
      rb_valid_q     <= rb_valid_d;
      busy_q         <= busy_d;
      cfg_done_q     <= cfg_done_d;
      fabric_reset_q <= fabric_reset_d;
    end
  end

  assign word_ready   = word_ready_q;
  assign scan_in      = piso_lsb;
  assign scan_en      = scan_en_q;
  assign scan_clk_en  = scan_clk_en_q;
  assign rb_bit       = rb_bit_q;
  assign rb_valid     = rb_valid_q;
  assign busy         = busy_q;
  assign cfg_done     = cfg_done_q;
  assign fabric_reset = fabric_reset_q;

endmodule

// File: tb/tb_cfg_scan_loader.sv
// Scoreboard bench for cfg_scan_loader: a fabric chain model feeds scan_out, and a
// reference chain built from the words the host sent predicts issued and read-back bits.
module tb_cfg_scan_loader;

  localparam int CL = 29;
  localparam int W  = 8;

  logic         clk = 1'b0;
  logic         reset, start, abort, word_valid;
  logic [W-1:0] word_data;
  logic         word_ready, scan_in, scan_en, scan_clk_en, scan_out;
  logic         rb_bit, rb_valid, busy, cfg_done, fabric_reset;

  cfg_scan_loader #(.CHAIN_LEN(CL), .WORD_WIDTH(W), .CNT_WIDTH(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .word_data    (word_data),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .scan_in      (scan_in),
    .scan_en      (scan_en),
    .scan_clk_en  (scan_clk_en),
    .scan_out     (scan_out),
    .rb_bit       (rb_bit),
    .rb_valid     (rb_valid),
    .busy         (busy),
    .cfg_done     (cfg_done),
    .fabric_reset (fabric_reset)
  );

  always #5 clk = ~clk;

  // Physical chain: head at the top, tail drives scan_out
  logic [CL-1:0] fabric = '0;
  assign scan_out = fabric[0];
  always @(posedge clk) if (scan_clk_en) fabric <= {scan_in, fabric[CL-1:1]};

  int checks = 0, failures = 0;
  int cyc = 0;
  bit exp_q[$];
  bit rb_q[$];
  bit model_chain[$];
  int pushed, issued, rb_cnt, rb_ones, hold, first_cyc, done_cyc;
  bit done_seen;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every issued bit pops the expectation queue and advances the reference chain
  always @(negedge clk) begin
    bit e;
    if (!reset) begin
      if (scan_clk_en) begin
        if (issued == 0) first_cyc = cyc;
        issued++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_bit actual=%0d expected=none t=%0t", scan_in, $time);
          e = scan_in;
        end else begin
          e = exp_q.pop_front();
          check("scan_in", scan_in, e);
        end
        check("scan_en_while_shifting", scan_en, 1);
        rb_q.push_back(model_chain.pop_front());
        model_chain.push_back(e);
      end else if (scan_en && issued > 0) begin
        hold++;
      end
      if (rb_valid) begin
        rb_cnt++;
        if (rb_bit) rb_ones++;
        if (rb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rb actual=%0d expected=none t=%0t", rb_bit, $time);
        end else begin
          check("rb_bit", rb_bit, rb_q.pop_front());
        end
      end
      if (cfg_done && !done_seen) begin
        done_seen = 1'b1;
        done_cyc  = cyc;
      end
    end
  end

  task automatic check_reset_vals(input string t);
    check({t, "_scan_in"}, scan_in, 0);
    check({t, "_scan_en"}, scan_en, 0);
    check({t, "_scan_clk_en"}, scan_clk_en, 0);
    check({t, "_word_ready"}, word_ready, 0);
    check({t, "_rb_bit"}, rb_bit, 0);
    check({t, "_rb_valid"}, rb_valid, 0);
    check({t, "_busy"}, busy, 0);
    check({t, "_cfg_done"}, cfg_done, 0);
    check({t, "_fabric_reset"}, fabric_reset, 1);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    issued = 0; rb_cnt = 0; rb_ones = 0; hold = 0; pushed = 0;
    first_cyc = 0; done_cyc = 0; done_seen = 1'b0;
    exp_q.delete();
    check("start_busy", busy, 1);
    check("start_fabric_reset", fabric_reset, 1);
    check("start_word_ready", word_ready, 1);
  endtask

  // Offer one word; on acceptance the chain still needs min(W, remaining) of its bits
  task automatic send_word(input logic [W-1:0] d, output bit ok);
    int n, nb;
    word_valid = 1'b1;
    word_data  = d;
    n = 0;
    while (!word_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!word_ready) begin
      check("word_accept_timeout", 0, 1);
      word_valid = 1'b0;
      ok = 1'b0;
    end else begin
      @(posedge clk);
      nb = (CL - pushed < W) ? CL - pushed : W;
      for (int b = 0; b < nb; b++) exp_q.push_back(d[b]);
      pushed += nb;
      #1;
      word_valid = 1'b0;
      ok = 1'b1;
    end
  endtask

  task automatic run_load(input logic [W-1:0] w0, w1, w2, w3,
                          input int g0, g1, g2, input bit pulse);
    logic [W-1:0] w[4];
    int g[3];
    int extra_bad, n, gsum;
    bit ok;
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    g[0] = g0; g[1] = g1; g[2] = g2;
    gsum = g0 + g1 + g2;
    do_start();
    for (int i = 0; i < 4; i++) begin
      send_word(w[i], ok);
      if (!ok) return;
      if (i < 3 && g[i] > 0) begin
        for (int j = 0; j < W - 1 + g[i]; j++) begin
          start = pulse && (j == W);
          @(posedge clk); #1;
        end
        start = 1'b0;
      end
    end
    word_valid = 1'b1;
    word_data  = W'($urandom);
    extra_bad  = 0;
    n = 0;
    while (!cfg_done && n < 100) begin
      if (word_ready) extra_bad++;
      @(posedge clk); #1;
      n++;
    end
    check("done_reached", cfg_done, 1);
    check("extra_word_ready", extra_bad, 0);
    check("fabric_reset_at_done", fabric_reset, 1);
    @(negedge clk); #1;
    check("bits_issued", issued, CL);
    check("rb_pulses", rb_cnt, CL);
    check("hold_cycles", hold, gsum);
    check("done_latency", done_cyc - first_cyc, CL + gsum);
    @(posedge clk); #1;
    word_valid = 1'b0;
    check("fabric_reset_release", fabric_reset, 0);
    check("done_held", cfg_done, 1);
    check("scan_en_in_done", scan_en, 0);
    check("busy_in_done", busy, 0);
  endtask

  task automatic run_random_load();
    run_load(W'($urandom), W'($urandom), W'($urandom), W'($urandom),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             1'($urandom_range(0, 1)));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    for (int i = 0; i < CL; i++) model_chain.push_back(1'b0);
    reset = 1'b1; start = 1'b0; abort = 1'b0; word_valid = 1'b0; word_data = '0;
    pushed = 0; issued = 0; rb_cnt = 0; rb_ones = 0; hold = 0;
    first_cyc = 0; done_cyc = 0; done_seen = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("por");
    reset = 1'b0;
    @(posedge clk); #1;

    // basic back-to-back load; last word 0x15 contributes only its low 5 bits
    run_load(8'hA5, 8'h3C, 8'hFF, 8'h15, 0, 0, 0, 1'b0);

    // five-cycle stall between the second and third word, with a stray start inside it
    run_load(W'($urandom), W'($urandom), W'($urandom), W'($urandom), 0, 5, 0, 1'b1);

    // read-back: all ones, then zeros must return 29 ones
    run_load(8'hFF, 8'hFF, 8'hFF, 8'hFF, 0, 0, 0, 1'b0);
    run_load(8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 1'b0);
    check("rb_ones", rb_ones, CL);

    // abort after ten issued bits
    do_start();
    send_word(W'($urandom), ok);
    send_word(W'($urandom), ok);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_scan_en", scan_en, 0);
    check("abort_scan_clk_en", scan_clk_en, 0);
    check("abort_word_ready", word_ready, 0);
    check("abort_cfg_done", cfg_done, 0);
    check("abort_fabric_reset", fabric_reset, 1);
    exp_q.delete();
    repeat (4) @(posedge clk);
    @(negedge clk); #1;
    check("abort_bits", issued, 10);
    @(posedge clk); #1;
    run_random_load();

    // asynchronous reset between clock edges
    do_start();
    send_word(W'($urandom), ok);
    send_word(W'($urandom), ok);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check_reset_vals("async");
    exp_q.delete();
    rb_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    run_random_load();

    for (int r = 0; r < 3; r++) run_random_load();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
